// File: rtl/regfile_scoreboard.sv
// Issue-interlock scoreboard: counts outstanding writes per architectural register
// and holds decode while a source is pending or a destination counter is full.
module regfile_scoreboard #(
  parameter int CNT_W       = 2,
  parameter int STALL_CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   issue_valid,
  input  logic [4:0]             rs_addr,
  input  logic [4:0]             rt_addr,
  input  logic                   rs_used,
  input  logic                   rt_used,
  input  logic                   wr_en,
  input  logic [4:0]             wr_addr,
  input  logic                   wb_valid,
  input  logic [4:0]             wb_addr,
  input  logic                   flush,
  output logic                   stall,
  output logic                   issue_fire,
  output logic [31:0]            pending_mask,
  output logic [STALL_CNT_W-1:0] stall_count,
  output logic                   wb_err
);

  localparam logic [CNT_W-1:0]       CNT_MAX   = '1;
  localparam logic [CNT_W-1:0]       CNT_ONE   = CNT_W'(1);
  localparam logic [STALL_CNT_W-1:0] STALL_MAX = '1;
  localparam logic [STALL_CNT_W-1:0] STALL_ONE = STALL_CNT_W'(1);

  // cnt[0] is held at zero so r0 can never be pending.
  logic [CNT_W-1:0] cnt [32];

  logic        rs_pend;
  logic        rt_pend;
  logic        wr_full;
  logic        hazard;
  logic        wb_hit;
  logic        wb_miss;
  logic [31:0] inc_vec;
  logic [31:0] dec_vec;

  // Hazards use pre-edge counts: a same-cycle writeback does not release a stall.
  always_comb begin
    rs_pend = rs_used && (rs_addr != 5'd0) && (cnt[rs_addr] != '0);
    rt_pend = rt_used && (rt_addr != 5'd0) && (cnt[rt_addr] != '0);
    wr_full = wr_en   && (wr_addr != 5'd0) && (cnt[wr_addr] == CNT_MAX);
    hazard  = issue_valid && (rs_pend || rt_pend || wr_full);
  end

  assign stall      = hazard && !flush;
  assign issue_fire = issue_valid && !hazard && !flush;

  assign wb_hit  = wb_valid && (wb_addr != 5'd0) && (cnt[wb_addr] != '0);
  assign wb_miss = wb_valid && !wb_hit;

  always_comb begin
    inc_vec = '0;
    dec_vec = '0;
    if (issue_fire && wr_en && (wr_addr != 5'd0)) begin
      inc_vec[wr_addr] = 1'b1;
    end
    if (wb_hit) begin
      dec_vec[wb_addr] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < 32; i++) begin
        cnt[i] <= '0;
      end
    end else begin
      cnt[0] <= '0;
      for (int i = 1; i < 32; i++) begin
        if (flush) begin
          cnt[i] <= '0;
        end else if (inc_vec[i] && !dec_vec[i]) begin
          cnt[i] <= cnt[i] + CNT_ONE;
        end else if (dec_vec[i] && !inc_vec[i]) begin
          cnt[i] <= cnt[i] - CNT_ONE;
        end
      end
    end
  end

  always_comb begin
    pending_mask = '0;
    for (int i = 0; i < 32; i++) begin
      pending_mask[i] = (cnt[i] != '0);
    end
  end

  // Error flag is sticky until reset; flush does not mask a stray writeback.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wb_err <= 1'b0;
    end else if (wb_miss) begin
      wb_err <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_count <= '0;
    end else if (stall && (stall_count != STALL_MAX)) begin
      stall_count <= stall_count + STALL_ONE;
    end
  end

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Bench for regfile_scoreboard: per-cycle compare against a behavioural
// pending-count model, directed scenarios with literal expectations, random traffic.
module tb_regfile_scoreboard;

  localparam int CNT_W       = 2;
  localparam int STALL_CNT_W = 16;
  localparam int CMAX        = (1 << CNT_W) - 1;
  localparam int SMAX        = (1 << STALL_CNT_W) - 1;

  logic                   clk = 1'b0;
  logic                   rst = 1'b0;
  logic                   issue_valid = 1'b0;
  logic [4:0]             rs_addr = '0;
  logic [4:0]             rt_addr = '0;
  logic                   rs_used = 1'b0;
  logic                   rt_used = 1'b0;
  logic                   wr_en = 1'b0;
  logic [4:0]             wr_addr = '0;
  logic                   wb_valid = 1'b0;
  logic [4:0]             wb_addr = '0;
  logic                   flush = 1'b0;
  logic                   stall;
  logic                   issue_fire;
  logic [31:0]            pending_mask;
  logic [STALL_CNT_W-1:0] stall_count;
  logic                   wb_err;

  int total = 0;
  int bad   = 0;

  int m_cnt [32];
  int m_sc  = 0;
  bit m_err = 1'b0;

  regfile_scoreboard #(.CNT_W(CNT_W), .STALL_CNT_W(STALL_CNT_W)) dut (
    .clk(clk), .rst(rst), .issue_valid(issue_valid),
    .rs_addr(rs_addr), .rt_addr(rt_addr), .rs_used(rs_used), .rt_used(rt_used),
    .wr_en(wr_en), .wr_addr(wr_addr), .wb_valid(wb_valid), .wb_addr(wb_addr),
    .flush(flush), .stall(stall), .issue_fire(issue_fire),
    .pending_mask(pending_mask), .stall_count(stall_count), .wb_err(wb_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: compare outputs, then advance the model to post-edge state.
  always @(negedge clk) begin
    bit          hz, e_stall, e_fire, dec_ok;
    logic [31:0] e_mask;
    if (!rst) begin
      for (int i = 0; i < 32; i++) m_cnt[i] = 0;
      m_sc  = 0;
      m_err = 1'b0;
    end
    hz = issue_valid && ((rs_used && rs_addr != 0 && m_cnt[rs_addr] != 0) ||
                         (rt_used && rt_addr != 0 && m_cnt[rt_addr] != 0) ||
                         (wr_en && wr_addr != 0 && m_cnt[wr_addr] == CMAX));
    e_stall = hz && !flush;
    e_fire  = issue_valid && !hz && !flush;
    e_mask  = '0;
    for (int i = 0; i < 32; i++) e_mask[i] = (m_cnt[i] != 0);
    chk("stall", 32'(stall), 32'(e_stall));
    chk("issue_fire", 32'(issue_fire), 32'(e_fire));
    chk("pending_mask", pending_mask, e_mask);
    chk("stall_count", 32'(stall_count), 32'(m_sc));
    chk("wb_err", 32'(wb_err), 32'(m_err));
    if (rst) begin
      dec_ok = wb_valid && wb_addr != 0 && m_cnt[wb_addr] != 0;
      if (wb_valid && !dec_ok) m_err = 1'b1;
      if (e_stall && m_sc < SMAX) m_sc++;
      if (flush) begin
        for (int i = 0; i < 32; i++) m_cnt[i] = 0;
      end else begin
        if (dec_ok) m_cnt[wb_addr]--;
        if (e_fire && wr_en && wr_addr != 0) m_cnt[wr_addr]++;
      end
    end
  end

  task automatic cyc(input bit iv, input int rs, input bit rsu, input int rt, input bit rtu,
                     input bit we, input int wa, input bit wbv, input int wba, input bit fl);
    @(posedge clk);
    #1;
    issue_valid = iv;
    rs_addr = 5'(rs); rs_used = rsu;
    rt_addr = 5'(rt); rt_used = rtu;
    wr_en = we; wr_addr = 5'(wa);
    wb_valid = wbv; wb_addr = 5'(wba);
    flush = fl;
    #1;
  endtask

  task automatic idle();
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic wr(input int r);
    cyc(1, 0, 0, 0, 0, 1, r, 0, 0, 0);
  endtask

  task automatic wb(input int r);
    cyc(0, 0, 0, 0, 0, 0, 0, 1, r, 0);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    idle(); idle();
    chk("idle_stall", 32'(stall), 32'd0);
    chk("idle_mask", pending_mask, 32'd0);
    chk("idle_sc", 32'(stall_count), 32'd0);
    chk("idle_err", 32'(wb_err), 32'd0);

    // RAW on r5 until writeback
    wr(5);
    chk("wr5_fire", 32'(issue_fire), 32'd1);
    cyc(1, 5, 1, 0, 0, 0, 0, 0, 0, 0);
    chk("raw5_stall", 32'(stall), 32'd1);
    chk("raw5_mask", 32'(pending_mask[5]), 32'd1);
    cyc(1, 5, 1, 0, 0, 0, 0, 0, 0, 0);
    chk("raw5_stall2", 32'(stall), 32'd1);
    cyc(1, 5, 1, 0, 0, 0, 0, 1, 5, 0);
    chk("raw5_wbcyc_stall", 32'(stall), 32'd1);
    cyc(1, 5, 1, 0, 0, 0, 0, 0, 0, 0);
    chk("raw5_rel_stall", 32'(stall), 32'd0);
    chk("raw5_rel_fire", 32'(issue_fire), 32'd1);
    chk("raw5_rel_mask", 32'(pending_mask[5]), 32'd0);

    // counter full on r7
    wr(7); wr(7); wr(7);
    cyc(1, 0, 0, 0, 0, 1, 7, 0, 0, 0);
    chk("full7_stall", 32'(stall), 32'd1);
    cyc(1, 0, 0, 0, 0, 1, 7, 1, 7, 0);
    chk("full7_wb_stall", 32'(stall), 32'd1);
    cyc(1, 0, 0, 0, 0, 1, 7, 0, 0, 0);
    chk("full7_fire", 32'(issue_fire), 32'd1);
    cyc(1, 0, 0, 0, 0, 1, 7, 0, 0, 0);
    chk("full7_again_stall", 32'(stall), 32'd1);
    idle();

    // simultaneous inc/dec on r9, then stray writeback
    wr(9);
    cyc(1, 0, 0, 0, 0, 1, 9, 1, 9, 0);
    chk("r9_fire", 32'(issue_fire), 32'd1);
    idle();
    chk("r9_mask", 32'(pending_mask[9]), 32'd1);
    cyc(1, 0, 0, 0, 0, 1, 9, 0, 0, 0);
    chk("r9_still1_fire", 32'(issue_fire), 32'd1);
    wb(9); wb(9);
    wb(0);
    idle();
    chk("wb0_err", 32'(wb_err), 32'd1);
    chk("wb0_r7_kept", 32'(pending_mask[7]), 32'd1);

    // flush with r3=2, r4=1
    wr(3); wr(3); wr(4);
    cyc(1, 0, 0, 0, 0, 1, 6, 0, 0, 1);
    chk("flush_fire", 32'(issue_fire), 32'd0);
    chk("flush_stall", 32'(stall), 32'd0);
    idle();
    chk("flush_mask", pending_mask, 32'd0);

    // r0 is never pending
    repeat (4) begin
      cyc(1, 0, 1, 0, 1, 1, 0, 0, 0, 0);
      chk("r0_fire", 32'(issue_fire), 32'd1);
    end
    idle();
    chk("r0_mask", pending_mask, 32'd0);

    // async reset with r5 pending
    wr(5);
    idle();
    chk("pre_rst_mask", 32'(pending_mask[5]), 32'd1);
    rst = 1'b0;
    #1;
    chk("async_rst_mask", pending_mask, 32'd0);
    chk("async_rst_err", 32'(wb_err), 32'd0);
    idle();
    rst = 1'b1;
    idle();

    // random traffic on a small register window
    for (int n = 0; n < 3000; n++) begin
      cyc($urandom_range(3) != 0, $urandom_range(7), $urandom_range(1), $urandom_range(7),
          $urandom_range(1), $urandom_range(2) != 0, $urandom_range(7),
          $urandom_range(2) == 0, $urandom_range(7), $urandom_range(40) == 0);
    end
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);

    // saturate the stall counter
    wr(5);
    for (int n = 0; n < 70000; n++) begin
      cyc(1, 5, 1, 0, 0, 0, 0, 0, 0, 0);
    end
    chk("sat_sc", 32'(stall_count), 32'hFFFF);
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    idle();
    chk("sat_sc_flush", 32'(stall_count), 32'hFFFF);

    @(negedge clk);
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
